// File: rtl/pipe_reg_chain.sv
// Elastic register chain: DEPTH stages of data + valid, with bubble compaction under
// backpressure, a registered occupancy count, and a synchronous flush.
module pipe_reg_chain #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    occupancy
);

   logic             valid_q [DEPTH];
   logic [WIDTH-1:0] data_q  [DEPTH];
   logic [CW-1:0]    occ_q;
   logic [DEPTH-1:0] can_load;
   logic             in_fire;
   logic             out_fire;

   assign out_fire  = valid_q[DEPTH-1] & out_ready & ~flush;
   assign in_ready  = can_load[0] & ~flush;
   assign in_fire   = in_valid & in_ready;
   assign out_valid = valid_q[DEPTH-1] & ~flush;
   assign out_data  = data_q[DEPTH-1];
   assign occupancy = occ_q;

   // Load permission ripples back from the output: a stage may load if it is empty or if
   // it is valid and its successor may load (i.e. it advances), which fills bubbles.
   always_comb begin
      can_load          = '0;
      can_load[DEPTH-1] = ~valid_q[DEPTH-1] | out_fire;
      for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
         can_load[i] = ~valid_q[i] | can_load[i+1];
      end
   end

   // Stage registers: loading stages take the upstream word and its valid qualifier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= '0;
         end
      end else begin
         if (can_load[0]) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
         end
         for (int i = 1; i < int'(DEPTH); i++) begin
            if (can_load[i]) begin
               valid_q[i] <= valid_q[i-1];
               data_q[i]  <= data_q[i-1];
            end
         end
      end
   end

   // Occupancy counter: tracks accepted-but-not-delivered words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
      end else if (flush) begin
         occ_q <= '0;
      end else if (in_fire && !out_fire) begin
         occ_q <= occ_q + CW'(1);
      end else if (out_fire && !in_fire) begin
         occ_q <= occ_q - CW'(1);
      end
   end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each data word; SHALL be legal for 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages; SHALL be legal for 1..16.
REQ-003 Parameter CW, default $clog2(DEPTH+1), occupancy counter width; SHALL NOT be overridden by users.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset; SHALL clear all state immediately on assertion, independent of clk.
REQ-006 flush  input  1  synchronous discard of all stored words.
REQ-007 in_valid  input  1  upstream word present on in_data.
REQ-008 in_ready  output  1  chain accepts a word this cycle.
REQ-009 in_data  input  WIDTH  upstream data word.
REQ-010 out_valid  output  1  stage DEPTH-1 holds a word.
REQ-011 out_ready  input  1  downstream accepts a word this cycle.
REQ-012 out_data  output  WIDTH  data word of stage DEPTH-1.
REQ-013 occupancy  output  CW  number of stages currently holding a valid word.

Function
REQ-014 Chain SHALL consist of DEPTH stages, 0 (input) to DEPTH-1 (output), each holding one data register and one valid bit.
REQ-015 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-016 Stage i SHALL be able to load when its valid bit is 0 or stage i advances; stage DEPTH-1 advances on an output transfer, stage i<DEPTH-1 advances when it is valid and stage i+1 can load.
REQ-017 in_ready SHALL equal (stage 0 can load) AND NOT flush; out_valid SHALL equal valid[DEPTH-1] AND NOT flush.
REQ-018 A stage that can load SHALL capture the upstream word (in_data for stage 0, stage i-1 otherwise) and set its valid bit to the upstream valid qualifier; a stage that cannot load SHALL hold data and valid unchanged.
REQ-019 With out_ready held 1 and no flush, a word accepted at edge N SHALL appear on out_data with out_valid=1 after edge N+DEPTH-1, i.e. latency DEPTH cycles and throughput one word per cycle.
REQ-020 Backpressure (out_ready=0) SHALL compact the chain: bubbles ahead of a stalled word SHALL be filled, and in_ready SHALL drop only when all DEPTH stages are valid.
REQ-021 Words SHALL leave in acceptance order; no word SHALL be duplicated, dropped or reordered except by flush or rst.
REQ-022 Full chain (occupancy=DEPTH) with out_ready=1: in_ready SHALL be 1 and simultaneous input and output transfers SHALL keep occupancy at DEPTH.
REQ-023 occupancy SHALL be a register incremented by 1 on input-only transfer, decremented by 1 on output-only transfer, unchanged on both or neither; SHALL never exceed DEPTH nor underflow below 0.
REQ-024 flush=1 at an edge SHALL clear all valid bits, all data registers to 0 and occupancy to 0; in_valid and out_ready SHALL be ignored that cycle (no transfer occurs).
REQ-025 out_data SHALL be driven directly from the stage DEPTH-1 register (no combinational path from in_data) for DEPTH>=1.
REQ-026 DEPTH=1 SHALL behave as a single elastic register: in_ready = NOT valid[0] OR out_ready, gated by NOT flush.

Reset
REQ-027 On rst=1: all valid bits 0, all data registers 0, occupancy 0, hence out_valid=0, out_data=0, in_ready=1 (when flush=0).
REQ-028 rst asserted mid-stream SHALL discard all stored words; after release the first accepted word SHALL be the first in_data presented with in_valid=1 and in_ready=1.
REQ-029 rst SHALL take priority over flush and all transfers.

Verification
REQ-030 Reset: assert rst mid-cycle with 3 words stored -> out_valid=0, out_data=0, occupancy=0 immediately, before next clk edge.
REQ-031 Streaming: DEPTH=4, out_ready=1, send 0x11,0x22,0x33 on consecutive edges -> 0x11 at out_data after 4th edge, then 0x22, 0x33 on following cycles, occupancy peaks at 3.
REQ-032 Fill/backpressure: out_ready=0, offer 6 words -> first 4 accepted, in_ready=0 after 4th, occupancy=4; raise out_ready -> 0x01..0x04 drained in order, in_ready returns 1 in the same cycle out_ready rises.
REQ-033 Full with simultaneous transfer: occupancy=4, in_valid=1, out_ready=1 for 5 edges -> occupancy stays 4, five words out in order.
REQ-034 Flush: occupancy=3, flush=1 with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0 that cycle, next cycle occupancy=0, out_data=0, offered word not stored.
REQ-035 Random stimulus at DEPTH=1 and DEPTH=16 with scoreboard -> in-order, lossless delivery, occupancy always equal to scoreboard count.
